// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Runtime-configurable serial pattern detector with a registered match pulse.
//   The pattern is received MSB first: pat[len-1] is the first bit to arrive.
//   The pattern, its length and the overlap mode are loaded through cfg_load.
//
//   Optional feature macro: SEQDET_CNT_EN
//     defined   -> match_cnt counts matches and saturates at its maximum value
//     undefined -> there is no counter and match_cnt is tied to 0
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active high
//   x            serial data bit, sampled only when in_valid=1
//   in_valid     qualifies x
//   cfg_load     latches cfg_* and flushes the history; this has priority over in_valid
//   cfg_pattern  pattern bits; the first bit received is bit [cfg_len-1]
//   cfg_len      pattern length; 0 disables detection; values above PAT_W are clamped
//   cfg_overlap  1 = matches may share bits, 0 = each match needs len fresh bits
//   y            one-cycle match pulse, registered
//   fill         number of valid history bits, saturating at PAT_W
//   match_cnt    saturating match counter
module seq_detect_param #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 'hCB,
  parameter int               DEF_LEN = 8,
  parameter bit               DEF_OVL = 1'b1,
  parameter int               CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       in_valid,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  output logic                       y,
  output logic [$clog2(PAT_W+1)-1:0] fill,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int LW = $clog2(PAT_W+1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat;
  logic [LW-1:0]    len;
  logic             ovl;

  logic [PAT_W-1:0] h_nxt;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    f_nxt;
  logic [LW-1:0]    len_ld;
  logic             match;

  always_comb begin
    h_nxt = {hist[PAT_W-2:0], x};
    f_nxt = (fill >= LW'(PAT_W)) ? fill : fill + 1'b1;
    mask  = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    // Only the low len bits of the history take part in the compare.
    match  = (len != '0) && (f_nxt >= len) && (((h_nxt ^ pat) & mask) == '0);
    len_ld = (cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= 1'b0;
      fill <= '0;
      hist <= '0;
      pat  <= DEF_PAT;
      len  <= LW'(DEF_LEN);
      ovl  <= DEF_OVL;
    end else if (cfg_load) begin
      pat  <= cfg_pattern;
      len  <= len_ld;
      ovl  <= cfg_overlap;
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (in_valid) begin
      hist <= h_nxt;
      // In non-overlap mode, clearing fill forces len fresh bits before the next match.
      fill <= (match && !ovl) ? '0 : f_nxt;
      y    <= match;
    end else begin
      y    <= 1'b0;
    end
  end

`ifdef SEQDET_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (!cfg_load && in_valid && match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       rst, x, in_valid, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       y;
  logic [3:0] fill;
  logic [1:0] match_cnt;

  seq_detect_param #(.PAT_W(8), .DEF_PAT(8'hCB), .DEF_LEN(8), .DEF_OVL(1'b1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y), .fill(fill), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int y; int fill; int cnt;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit cnt_en;

  // reference model state
  logic [7:0] m_hist, m_pat;
  int m_fill, m_len, m_cnt, m_y;
  bit m_ovl;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(bit r, bit ld, bit v, bit xb);
    int  f;
    bit  hit;
    if (r) begin
      m_y = 0; m_fill = 0; m_hist = '0; m_cnt = 0;
      m_pat = 8'hCB; m_len = 8; m_ovl = 1'b1;
    end else if (ld) begin
      m_pat  = cfg_pattern;
      m_len  = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
      m_ovl  = cfg_overlap;
      m_hist = '0; m_fill = 0; m_y = 0;
    end else if (v) begin
      m_hist = {m_hist[6:0], xb};
      f = (m_fill + 1 > 8) ? 8 : m_fill + 1;
      hit = (m_len != 0) && (f >= m_len);
      for (int i = 0; i < m_len; i++) begin
        if (m_hist[i] != m_pat[i]) hit = 0;
      end
      m_fill = (hit && !m_ovl) ? 0 : f;
      m_y = hit;
      if (hit && cnt_en && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_y = 0;
    end
  endtask

  task automatic step(bit r, bit ld, bit v, bit xb);
    exp_t e;
    rst = r; cfg_load = ld; in_valid = v; x = xb;
    model_step(r, ld, v, xb);
    sb.push_back('{m_y, m_fill, m_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("y", int'(y), e.y);
    check("fill", int'(fill), e.fill);
    check("cnt", int'(match_cnt), e.cnt);
    if (y === 1'b1) pulses++;
  endtask

  task automatic send(bit b);
    step(0, 0, 1, b);
  endtask

  task automatic idle();
    step(0, 0, 0, 0);
  endtask

  task automatic load(logic [7:0] p, logic [3:0] l, bit o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(0, 1, 0, 0);
  endtask

  task automatic stream(logic [15:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  initial begin
`ifdef SEQDET_CNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    rst = 1; x = 0; in_valid = 0; cfg_load = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    m_hist = '0; m_pat = 8'hCB; m_fill = 0; m_len = 8; m_cnt = 0; m_y = 0; m_ovl = 1;

    // reset defaults and the default 11001011 pattern
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    check("rst_y", int'(y), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_cnt", int'(match_cnt), 0);
    pulses = 0;
    stream(16'hCB, 8);
    check("t1_y", int'(y), 1);
    check("t1_fill", int'(fill), 8);
    check("t1_cnt", int'(match_cnt), cnt_en ? 1 : 0);
    check("t1_pulses", pulses, 1);

    // overlapping 101
    load(8'b101, 3, 1);
    pulses = 0;
    stream(16'b10101, 5);
    check("t2_pulses", pulses, 2);
    check("t2_cnt", int'(match_cnt), cnt_en ? 3 : 0);

    // non-overlapping 101
    load(8'b101, 3, 0);
    pulses = 0;
    stream(16'b10101, 5);
    check("t3_pulses", pulses, 1);
    stream(16'b01, 2);
    check("t3_y", int'(y), 1);
    check("t3_pulses2", pulses, 2);

    // idle gaps between valid bits
    load(8'b101, 3, 1);
    pulses = 0;
    send(1); idle(); send(0); idle(); idle(); send(1); idle();
    send(0); idle(); send(1);
    check("t4_pulses", pulses, 2);

    // cfg_load flushes a partial match
    load(8'b101, 3, 1);
    send(1); send(0);
    load(8'b101, 3, 1);
    check("t5_fill_flush", int'(fill), 0);
    pulses = 0;
    send(1);
    check("t5_fill1", int'(fill), 1);
    send(0); send(1);
    check("t5_pulses", pulses, 1);

    // reset mid-pattern
    send(1); send(0);
    step(1, 0, 1, 1);
    check("t5_rst_fill", int'(fill), 0);
    check("t5_rst_cnt", int'(match_cnt), 0);
    load(8'b101, 3, 1);
    pulses = 0;
    send(1);
    check("t5_rst_pulses", pulses, 0);

    // cfg_load and in_valid together: the bit is dropped
    cfg_pattern = 8'b101; cfg_len = 3; cfg_overlap = 1;
    step(0, 1, 1, 1);
    pulses = 0;
    send(0); send(1);
    check("t5_drop_pulses", pulses, 0);
    check("t5_drop_fill", int'(fill), 2);

    // len=0 disables detection
    load(8'b0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)));
    check("t6_len0_pulses", pulses, 0);

    // cfg_len above PAT_W is clamped
    load(8'hCB, 15, 1);
    pulses = 0;
    stream(16'hCB, 8);
    check("t6_clamp_pulses", pulses, 1);
    check("t6_clamp_fill", int'(fill), 8);

    // counter saturation
    load(8'b101, 3, 1);
    stream(16'b1010101010, 10);
    check("t6_sat_cnt", int'(match_cnt), cnt_en ? 3 : 0);

    // constrained-random traffic checked against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1, 0, 1, 1);
      end else if (r < 6) begin
        cfg_pattern = 8'($urandom);
        cfg_len = 4'($urandom_range(0, 15));
        cfg_overlap = 1'($urandom_range(0, 1));
        step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 20) begin
        load({5'($urandom), 3'b101}, 3, 1'($urandom_range(0, 1)));
      end else if (r < 35) begin
        idle();
      end else begin
        send(1'($urandom_range(0, 1)));
      end
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
